dpram_stream_writer: RTL
========================

// Module: dpram_stream_writer
// PURPOSE
//  Sequential loader for the write side of the dual-port block-RAM tables. Read ports stay on dprom.
//  Takes a valid/ready word stream, or a constant fill value, and writes LENGTH consecutive words
//  from a base address, wrapping modulo DEPTH. Write-port outputs are registered.
//  Used to load or clear coefficient/lookup tables at runtime.
// PARAMETERS
//  DWIDTH  128  data word width, matches the RAM word
//  AWIDTH  8    RAM address width; DEPTH = 1<<AWIDTH
// PORTS
//  clk        in   1          single clock, all logic rising-edge
//  rst_n      in   1          asynchronous active-low reset
//  start      in   1          one-cycle request; sampled only in IDLE
//  fill       in   1          sampled with start: 1 = write fill_data, 0 = write stream
//  base_addr  in   AWIDTH     first write address, sampled with start
//  length     in   AWIDTH+1   word count 0..DEPTH, sampled with start
//  fill_data  in   DWIDTH     constant word for fill mode, sampled with start
//  abort      in   1          terminates the job at once
//  s_data     in   DWIDTH     stream word
//  s_valid    in   1          stream word valid
//  s_ready    out  1          stream word accepted when s_valid & s_ready
//  wr_en      out  1          RAM write strobe (registered)
//  wr_addr    out  AWIDTH     RAM write address (registered)
//  wr_data    out  DWIDTH     RAM write data (registered)
//  busy       out  1          job in progress or final write still on outputs
//  done       out  1          one-cycle pulse on successful completion
// BEHAVIOUR
//  Reset: state IDLE; wr_en, wr_addr, wr_data, done, s_ready and busy all 0; counters 0.
//  FSM: IDLE -> WRITE on start when length != 0.
//       IDLE -> IDLE on start when length == 0, with done pulsed next cycle and no wr_en.
//       WRITE -> IDLE on acceptance of word number length, or on abort.
//  s_ready = (state == WRITE) & ~fill_mode. It is driven from registers only and never depends on s_valid.
//  Stream mode: each handshake registers wr_en=1, wr_addr=addr, wr_data=s_data on the next edge.
//   Latency is 1 clk from handshake to wr_en. s_valid gaps give wr_en=0 that cycle.
//  Fill mode: one word accepted every WRITE cycle, wr_data=fill_data. Writes are back-to-back, length cycles.
//  addr: starts at base_addr, +1 per accepted word, wraps DEPTH-1 -> 0.
//   length == DEPTH writes every location exactly once.
//  count: AWIDTH+1 bits, so length == DEPTH does not overflow.
//  done is registered and asserts on the same edge as the final wr_en, for exactly 1 cycle.
//  busy = (state != IDLE) | wr_en. It rises the cycle after start and falls the cycle after the final wr_en.
//  start while in WRITE is ignored: no restart and no latching of new parameters.
//  abort in WRITE:
//   - a word handshaken in the same cycle is discarded and not written;
//   - a write already registered still completes on the next cycle;
//   - return to IDLE with no done pulse.
//  abort in IDLE has no effect. start and abort in the same cycle in IDLE: abort wins and no job starts.
//  rst_n low mid-job: outputs go to reset values immediately, the job is lost and partial writes stay in the RAM.
//  wr_en never asserts outside a job. At most one write per clk.
// TESTING
//  1. Stream, base=0x10, len=4, s_valid held high, data A..D:
//     -> wr_en on 4 consecutive cycles, addr 0x10..0x13, data A..D; done with 4th write; busy falls next cycle.
//  2. Wrap: base=DEPTH-2, len=4, stream 1,2,3,4 -> addresses DEPTH-2, DEPTH-1, 0, 1 in order.
//  3. Fill: len=DEPTH, fill_data=0 -> s_ready stays 0; DEPTH back-to-back writes covering every address once; one done.
//  4. Backpressure: s_valid toggles 1,0,1,1,0,1, len=4 -> exactly 4 writes, in order, each 1 clk after its handshake.
//  5. Edge cases:
//     len=0 start -> no wr_en, done 1 clk later;
//     start during a job -> ignored, job unaffected;
//     abort after 2 words of a len=5 job -> exactly 2 writes, no done, back in IDLE.
//  6. rst_n low mid fill job -> outputs 0 at once; after release, a new start runs a clean job.

Source files
------------

// File: rtl/dpram_stream_writer.sv
// dpram_stream_writer: sequential loader for the write port of the dual-port
// block-RAM tables. It copies a valid/ready word stream, or repeats a constant
// fill word, into LENGTH consecutive addresses starting at a base address.
// Addresses wrap modulo DEPTH. All write-port outputs are registered.
module dpram_stream_writer #(
  parameter int DWIDTH = 128,
  parameter int AWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              fill,
  input  logic [AWIDTH-1:0] base_addr,
  input  logic [AWIDTH:0]   length,
  input  logic [DWIDTH-1:0] fill_data,
  input  logic              abort,
  input  logic [DWIDTH-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              wr_en,
  output logic [AWIDTH-1:0] wr_addr,
  output logic [DWIDTH-1:0] wr_data,
  output logic              busy,
  output logic              done
);

  typedef enum logic {
    IDLE,
    WRITE
  } state_t;

  state_t              state, state_next;
  logic                fill_mode, fill_mode_next;
  logic [DWIDTH-1:0]   fill_word, fill_word_next;
  logic [AWIDTH-1:0]   addr, addr_next;
  logic [AWIDTH:0]     remaining, remaining_next;
  logic                wr_en_next;
  logic [AWIDTH-1:0]   wr_addr_next;
  logic [DWIDTH-1:0]   wr_data_next;
  logic                done_next;
  logic                accept;

  // s_ready and busy come purely from registers so they never depend on s_valid.
  always_comb begin
    s_ready = (state == WRITE) & ~fill_mode;
    busy    = (state != IDLE) | wr_en;
    accept  = (state == WRITE) & (fill_mode | s_valid);
  end

  // Next-state and next-output logic; remaining counts words still to write.
  always_comb begin
    state_next     = state;
    fill_mode_next = fill_mode;
    fill_word_next = fill_word;
    addr_next      = addr;
    remaining_next = remaining;
    wr_en_next     = 1'b0;
    wr_addr_next   = wr_addr;
    wr_data_next   = wr_data;
    done_next      = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          fill_mode_next = fill;
          fill_word_next = fill_data;
          addr_next      = base_addr;
          remaining_next = length;
          if (length == '0) begin
            done_next = 1'b1;
          end else begin
            state_next = WRITE;
          end
        end
      end
      WRITE: begin
        if (abort) begin
          state_next     = IDLE;
          remaining_next = '0;
        end else if (accept) begin
          wr_en_next     = 1'b1;
          wr_addr_next   = addr;
          wr_data_next   = fill_mode ? fill_word : s_data;
          addr_next      = addr + 1'b1;
          remaining_next = remaining - 1'b1;
          if (remaining == 1) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Job parameters, counters and the registered write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_mode <= 1'b0;
      fill_word <= '0;
      addr      <= '0;
      remaining <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      done      <= 1'b0;
    end else begin
      fill_mode <= fill_mode_next;
      fill_word <= fill_word_next;
      addr      <= addr_next;
      remaining <= remaining_next;
      wr_en     <= wr_en_next;
      wr_addr   <= wr_addr_next;
      wr_data   <= wr_data_next;
      done      <= done_next;
    end
  end

endmodule
